// File: rtl/mem_write_queue.sv
// DEPTH-entry write queue: buffers {addr,data} requests and drains them to memory over mem_write/mem_resp.
// Optional macro MEM_WRITE_UPDATE_FLAG_EN: entries carry an MSB flag; flag=0 entries are dropped without a write.
module mem_write_queue #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16,
`ifdef MEM_WRITE_UPDATE_FLAG_EN
  localparam int INPUT_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH
`else
  localparam int INPUT_WIDTH = ADDR_WIDTH + DATA_WIDTH
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INPUT_WIDTH-1:0]   data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     mem_write,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_resp,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_WIDTH-1:0]     wr_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                 state;
  logic [INPUT_WIDTH-1:0] fifo [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       occ;
  logic [OCC_W-1:0]       occ_next;
  logic [INPUT_WIDTH-1:0] head;
  logic                   head_keep;
  logic                   push;
  logic                   pop;

  assign head = fifo[rd_ptr];

`ifdef MEM_WRITE_UPDATE_FLAG_EN
  assign head_keep = head[INPUT_WIDTH-1];
`else
  assign head_keep = 1'b1;
`endif

  // Full refuses a push even when the head retires in the same cycle.
  assign ready_o = (occ != OCC_W'(DEPTH));
  assign push    = valid_i & ready_o;
  assign pop     = (state == WRITE) & (~head_keep | mem_resp);

  always_comb begin
    occ_next = occ;
    if (push & ~pop)
      occ_next = occ + 1'b1;
    else if (pop & ~push)
      occ_next = occ - 1'b1;
  end

  // Payload storage carries no reset; outputs are gated by the FSM instead.
  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      wr_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (pop & head_keep)
        wr_count <= wr_count + 1'b1;
      occ <= occ_next;
      case (state)
        IDLE:    if (occ_next != '0) state <= WRITE;
        WRITE:   if (occ_next == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_write = (state == WRITE) & head_keep;
  assign mem_addr  = (state == WRITE) ? head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign mem_wdata = (state == WRITE) ? head[DATA_WIDTH-1:0] : '0;
  assign occupancy = occ;
  assign done      = (occ == '0) & (state == IDLE);

endmodule

// File: tb/tb_mem_write_queue.sv
// Randomized scoreboard bench for mem_write_queue with a queue-level reference model.
module tb_mem_write_queue;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int CW = 4;
`ifdef MEM_WRITE_UPDATE_FLAG_EN
  localparam int IW = 1 + AW + DW;
  localparam bit FLAG_EN = 1'b1;
`else
  localparam int IW = AW + DW;
  localparam bit FLAG_EN = 1'b0;
`endif

  typedef struct {
    bit            flag;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [IW-1:0]         data_i;
  logic                  valid_i;
  logic                  ready_o;
  logic                  mem_write;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic                  mem_resp;
  logic                  done;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CW-1:0]         wr_count;

  mem_write_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .done(done), .occupancy(occupancy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  ent_t          mq[$];   // entries the queue should hold, head first
  ent_t          sb[$];   // writes expected on the memory port, in order
  ent_t          cur;
  bit            cur_v = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input bit f, input int unsigned a, input int unsigned d);
    ent_t e;
    e.flag = f;
    e.addr = AW'(a);
    e.data = DW'(d);
    return e;
  endfunction

  function automatic logic [IW-1:0] pack(input ent_t e);
`ifdef MEM_WRITE_UPDATE_FLAG_EN
    return {e.flag, e.addr, e.data};
`else
    return {e.addr, e.data};
`endif
  endfunction

  // Reference model: one edge = retire head if allowed, then accept a request if not full at edge start.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      sb.delete();
      m_cnt = '0;
    end else begin
      bit do_push;
      do_push = cur_v && (mq.size() != DEPTH);
      if (mq.size() > 0 && (!mq[0].flag || mem_resp)) begin
        if (mq[0].flag) m_cnt = m_cnt + 1'b1;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back(cur);
    end
  end

  // Monitor: compares status against the model and memory writes against the scoreboard.
  initial forever begin
    @(negedge clk);
    #1;
    check("ready_o", 64'(ready_o), 64'(mq.size() != DEPTH));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("done", 64'(done), 64'(mq.size() == 0));
    check("mem_write", 64'(mem_write), 64'(mq.size() > 0 && mq[0].flag));
    check("wr_count", 64'(wr_count), 64'(m_cnt));
    if (mq.size() == 0) begin
      check("idle_addr", 64'(mem_addr), 64'(0));
      check("idle_wdata", 64'(mem_wdata), 64'(0));
    end else begin
      check("head_addr", 64'(mem_addr), 64'(mq[0].addr));
    end
    if (mem_write) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_write: got write to %0h expected no write at %0t", mem_addr, $time);
      end else begin
        check("sb_addr", 64'(mem_addr), 64'(sb[0].addr));
        check("sb_wdata", 64'(mem_wdata), 64'(sb[0].data));
        if (mem_resp) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input bit v, input ent_t e, input bit resp, output bit acc);
    @(negedge clk);
    cur_v    = v;
    cur      = e;
    valid_i  = v;
    data_i   = pack(e);
    mem_resp = resp;
    acc = v && (mq.size() != DEPTH);
    if (acc && e.flag) sb.push_back(e);
  endtask

  task automatic idle(input bit resp);
    bit acc;
    step(1'b0, mk(1'b1, 0, 0), resp, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cur_v = 1'b0; valid_i = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && mq.size() != 0; k++) idle(1'b1);
    idle(1'b0);
    #2;
    check("drained", 64'(occupancy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    bit   have;
    ent_t pend;

    rst_n = 1'b0; valid_i = 1'b0; mem_resp = 1'b0; data_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset while a write is outstanding.
    step(1'b1, mk(1'b1, 'h10, 'hAA), 1'b0, acc);
    idle(1'b0);
    #2;
    check("mid_write_before", 64'(mem_write), 64'(1));
    @(negedge clk);
    rst_n = 1'b0; cur_v = 1'b0; valid_i = 1'b0; mem_resp = 1'b0;
    #2;
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_done", 64'(done), 64'(1));
    check("rst_ready", 64'(ready_o), 64'(1));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; mem_resp = 1'b1;
    repeat (3) idle(1'b1);
    #2;
    check("late_resp_count", 64'(wr_count), 64'(0));

    // Single write: push cycle 0, write cycle 1, resp cycle 3, done cycle 4.
    step(1'b1, mk(1'b1, 'h100, 'hDEAD), 1'b0, acc);
    idle(1'b0);
    #2;
    check("single_write", 64'(mem_write), 64'(1));
    check("single_addr", 64'(mem_addr), 64'('h100));
    check("single_data", 64'(mem_wdata), 64'('hDEAD));
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    #2;
    check("single_done", 64'(done), 64'(1));
    check("single_count", 64'(wr_count), 64'(1));

    // Fill to full with no responses, fifth request held until space frees.
    for (int i = 0; i < 4; i++) step(1'b1, mk(1'b1, 'h20 + i * 8, 'h50 + i), 1'b0, acc);
    step(1'b1, mk(1'b1, 'h40, 'h54), 1'b0, acc);
    #2;
    check("full_ready", 64'(ready_o), 64'(0));
    check("full_occupancy", 64'(occupancy), 64'(4));
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) step(1'b1, mk(1'b1, 'h40, 'h54), k >= 2, acc);
    drain();
    check("fill_count", 64'(wr_count), 64'(6));

    // Back-to-back drain of four queued entries.
    for (int i = 0; i < 4; i++) step(1'b1, mk(1'b1, 'h200 + i * 4, 'h70 + i), 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      #2;
      check("b2b_write", 64'(mem_write), 64'(1));
      check("b2b_addr", 64'(mem_addr), 64'('h200 + i * 4));
    end
    idle(1'b0);
    #2;
    check("b2b_done", 64'(done), 64'(1));
    check("b2b_count", 64'(wr_count), 64'(10));

    // Counter wrap: 17 writes into a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) step(1'b1, mk(1'b1, i, i + 1), 1'b1, acc);
    end
    drain();
    check("wrap_count", 64'(wr_count), 64'(1));

`ifdef MEM_WRITE_UPDATE_FLAG_EN
    do_reset();
    step(1'b1, mk(1'b1, 'h0, 'h1), 1'b1, acc);
    step(1'b1, mk(1'b0, 'h8, 'h2), 1'b1, acc);
    step(1'b1, mk(1'b1, 'h10, 'h3), 1'b1, acc);
    drain();
    check("flag_count", 64'(wr_count), 64'(2));
`endif

    // Randomized traffic.
    do_reset();
    have = 1'b0;
    pend = mk(1'b1, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (!have && $urandom_range(0, 99) < 60) begin
        pend = mk(FLAG_EN ? ($urandom_range(0, 3) != 0) : 1'b1, $urandom, $urandom);
        have = 1'b1;
      end
      step(have, pend, $urandom_range(0, 99) < 50, acc);
      if (acc) have = 1'b0;
    end
    drain();
    check("final_count", 64'(wr_count), 64'(m_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
